fdse_shift_bank: RTL and testbench

Parametrised, multi-bit successor to the single-bit set/enable flip-flop primitive: a WIDTH-bit, DEPTH-stage clock-enabled shift register with synchronous set, asynchronous clear, a dynamically addressed tap, and a fill tracker. It belongs to the Verilator-compatible Xilinx primitive library. It models SRL-style delay lines and register banks for simulation, and replaces chains of per-bit FDSE/FDCE instances.

---
 rtl/fdse_shift_bank.sv | 100 ++++++++++
 tb/tb_fdse_shift_bank.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fdse_shift_bank.sv
// fdse_shift_bank: WIDTH-bit, DEPTH-stage clock-enabled shift register.
// It has an asynchronous clear, a synchronous set, a tap with a clamped
// address, and a fill tracker. It is a multi-bit successor to the FDSE
// primitive and is intended for SRL-style delay lines.
module fdse_shift_bank #(
  parameter int unsigned      WIDTH         = 8,
  parameter int unsigned      DEPTH         = 16,
  parameter int unsigned      AW            = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter logic [WIDTH-1:0] INIT          = {WIDTH{1'b0}},
  parameter logic             IS_C_INVERTED = 1'b0,
  parameter logic             IS_D_INVERTED = 1'b0,
  parameter logic             IS_S_INVERTED = 1'b0
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             CE,
  input  logic             S,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    A,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_LAST,
  output logic             FILLED
);

  localparam int unsigned    CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);
  localparam logic [AW-1:0]  TAP_MAX  = AW'(DEPTH - 1);

  // The power-up contents come from INIT. A clear always forces zero, not INIT.
  logic [WIDTH-1:0] stage_q [DEPTH] = '{default: INIT};
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [CW-1:0]    cnt_q = '0;
  logic [CW-1:0]    cnt_d;

  logic             clk_s;
  logic             set_s;
  logic [WIDTH-1:0] din_s;
  logic [AW-1:0]    tap_idx_s;

  // Inversion parameters are folded in once, so the logic below only sees
  // an active-high set and a rising edge.
  assign clk_s = C ^ IS_C_INVERTED;
  assign set_s = S ^ IS_S_INVERTED;
  assign din_s = D ^ {WIDTH{IS_D_INVERTED}};

  // Next-state: set overrides shift, shift overrides hold.
  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (set_s) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_d[k] = {WIDTH{1'b1}};
      end
      cnt_d = CNT_FULL;
    end else if (CE) begin
      stage_d[0] = din_s;
      for (int k = 1; k < DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
      end
      if (cnt_q == CNT_FULL) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      stage_d = stage_q;
      cnt_d   = cnt_q;
    end
  end

  // State register: the clear acts on its level, and while it is high it
  // masks every active edge.
  always_ff @(posedge clk_s or posedge CLR) begin
    if (CLR) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
      cnt_q <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  // Tap address clamp: an address past the last stage reads the last stage
  // instead of indexing out of range.
  always_comb begin
    tap_idx_s = A;
    if (A > TAP_MAX) begin
      tap_idx_s = TAP_MAX;
    end else begin
      tap_idx_s = A;
    end
  end

  assign Q      = stage_q[tap_idx_s];
  assign Q_LAST = stage_q[DEPTH-1];
  assign FILLED = (cnt_q == CNT_FULL);

endmodule

// File: tb/tb_fdse_shift_bank.sv
// Directed bench for fdse_shift_bank. A main table drives a DEPTH=4 bank.
// Short sequences cover the clear, clamp, inversion and falling-edge variants.
module tb_fdse_shift_bank;

  typedef struct {
    logic       s;
    logic       ce;
    logic [7:0] d;
    logic [1:0] a;
    logic [7:0] q;
    logic [7:0] ql;
    logic       f;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  logic       C = 1'b0;
  logic [7:0] D = 8'h00;

  // u0: DEPTH=4, INIT=A5
  logic clr0 = 1'b0, ce0 = 1'b0, s0 = 1'b0;
  logic [1:0] a0 = 2'd0;
  logic [7:0] q0, ql0;
  logic f0;
  // u1: DEPTH=5, D inverted
  logic clr1 = 1'b0, ce1 = 1'b0, s1 = 1'b0;
  logic [2:0] a1 = 3'd0;
  logic [7:0] q1, ql1;
  logic f1;
  // u2: S active-low
  logic clr2 = 1'b0, ce2 = 1'b0, s2 = 1'b1;
  logic [1:0] a2 = 2'd0;
  logic [7:0] q2, ql2;
  logic f2;
  // u3: falling-edge clock
  logic clr3 = 1'b0, ce3 = 1'b0, s3 = 1'b0;
  logic [1:0] a3 = 2'd0;
  logic [7:0] q3, ql3;
  logic f3;

  fdse_shift_bank #(.WIDTH(8), .DEPTH(4), .INIT(8'hA5)) u0 (
    .C(C), .CLR(clr0), .CE(ce0), .S(s0), .D(D), .A(a0),
    .Q(q0), .Q_LAST(ql0), .FILLED(f0));

  fdse_shift_bank #(.WIDTH(8), .DEPTH(5), .IS_D_INVERTED(1'b1)) u1 (
    .C(C), .CLR(clr1), .CE(ce1), .S(s1), .D(D), .A(a1),
    .Q(q1), .Q_LAST(ql1), .FILLED(f1));

  fdse_shift_bank #(.WIDTH(8), .DEPTH(4), .IS_S_INVERTED(1'b1)) u2 (
    .C(C), .CLR(clr2), .CE(ce2), .S(s2), .D(D), .A(a2),
    .Q(q2), .Q_LAST(ql2), .FILLED(f2));

  fdse_shift_bank #(.WIDTH(8), .DEPTH(4), .IS_C_INVERTED(1'b1)) u3 (
    .C(C), .CLR(clr3), .CE(ce3), .S(s3), .D(D), .A(a3),
    .Q(q3), .Q_LAST(ql3), .FILLED(f3));

  always #5 C = ~C;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 8'h01, 2'd0, 8'h01, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'h02, 2'd1, 8'h01, 8'h00, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'h03, 2'd2, 8'h01, 8'h00, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 8'h04, 2'd3, 8'h01, 8'h01, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 8'h77, 2'd0, 8'h04, 8'h01, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 8'h05, 2'd0, 8'h05, 8'h02, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 2'd1, 8'h04, 8'h02, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 8'h00, 2'd2, 8'hFF, 8'hFF, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 8'h10, 2'd0, 8'h10, 8'hFF, 1'b1};

    // Power-up values come from INIT.
    #1;
    check("t0_qlast", ql0, 8'hA5);
    check("t0_q", q0, 8'hA5);
    check("t0_filled", {7'd0, f0}, 8'h00);

    // A CLR pulse between edges clears the bank without any clock edge.
    @(negedge C);
    clr0 = 1'b1;
    #1;
    check("clr_q", q0, 8'h00);
    check("clr_qlast", ql0, 8'h00);
    check("clr_filled", {7'd0, f0}, 8'h00);
    #1 clr0 = 1'b0;

    // Table: shift, fill, hold, set.
    for (int i = 0; i < 9; i++) begin
      @(negedge C);
      s0 = vecs[i].s; ce0 = vecs[i].ce; D = vecs[i].d; a0 = vecs[i].a;
      @(posedge C);
      #1;
      check($sformatf("vec%0d_q", i), q0, vecs[i].q);
      check($sformatf("vec%0d_qlast", i), ql0, vecs[i].ql);
      check($sformatf("vec%0d_filled", i), {7'd0, f0}, {7'd0, vecs[i].f});
    end
    s0 = 1'b0; ce0 = 1'b0;
    // Tap is combinational: state [10,FF,FF,FF]
    a0 = 2'd1;
    #1 check("tap_a1", q0, 8'hFF);
    a0 = 2'd0;
    #1 check("tap_a0", q0, 8'h10);

    // CLR held across two edges wins over S and CE.
    @(negedge C);
    clr0 = 1'b1; s0 = 1'b1; ce0 = 1'b1; D = 8'hEE;
    for (int i = 0; i < 2; i++) begin
      @(posedge C);
      #1;
      check($sformatf("clrhold%0d_q", i), q0, 8'h00);
      check($sformatf("clrhold%0d_qlast", i), ql0, 8'h00);
      check($sformatf("clrhold%0d_filled", i), {7'd0, f0}, 8'h00);
    end
    @(negedge C);
    clr0 = 1'b0; s0 = 1'b0; ce0 = 1'b1; D = 8'h5A; a0 = 2'd0;
    @(posedge C);
    #1;
    ce0 = 1'b0;
    check("rel_stage0", q0, 8'h5A);
    a0 = 2'd1;
    #1 check("rel_stage1", q0, 8'h00);
    check("rel_filled", {7'd0, f0}, 8'h00);

    // u1: DEPTH=5 with inverted D. Disabled cycles neither shift nor count.
    @(negedge C);
    ce1 = 1'b1; D = 8'h0F;
    @(negedge C);
    D = 8'h3C;
    @(negedge C);
    ce1 = 1'b0; D = 8'h55;
    repeat (3) @(negedge C);
    a1 = 3'd0;
    #1 check("u1_gate_s0", q1, 8'hC3);
    a1 = 3'd1;
    #1 check("u1_gate_s1", q1, 8'hF0);
    check("u1_gate_filled", {7'd0, f1}, 8'h00);
    ce1 = 1'b1; D = 8'hFF;
    @(negedge C);
    D = 8'h00;
    @(negedge C);
    #1 check("u1_cnt4_filled", {7'd0, f1}, 8'h00);
    D = 8'h81;
    @(negedge C);
    ce1 = 1'b0;
    #1 check("u1_cnt5_filled", {7'd0, f1}, 8'h01);
    // Stages are now [7E,FF,00,C3,F0].
    a1 = 3'd7;
    #1 check("u1_clamp7", q1, 8'hF0);
    a1 = 3'd5;
    #1 check("u1_clamp5", q1, 8'hF0);
    a1 = 3'd3;
    #1 check("u1_a3", q1, 8'hC3);
    a1 = 3'd0;
    #1 check("u1_a0", q1, 8'h7E);
    check("u1_qlast", ql1, 8'hF0);

    // u2: S is active-low, so S=1 is idle and S=0 sets every stage.
    @(negedge C);
    ce2 = 1'b1; s2 = 1'b1; D = 8'h12;
    @(posedge C);
    #1 check("u2_idle_q", q2, 8'h12);
    check("u2_idle_filled", {7'd0, f2}, 8'h00);
    @(negedge C);
    s2 = 1'b0; D = 8'h00;
    @(posedge C);
    #1;
    s2 = 1'b1; ce2 = 1'b0;
    check("u2_set_q", q2, 8'hFF);
    check("u2_set_qlast", ql2, 8'hFF);
    check("u2_set_filled", {7'd0, f2}, 8'h01);

    // u3: the bank shifts only on falling edges.
    @(negedge C);
    #1;
    ce3 = 1'b1; D = 8'h3C; a3 = 2'd0;
    @(posedge C);
    #1 check("u3_rise_q", q3, 8'h00);
    @(negedge C);
    #1;
    ce3 = 1'b0;
    check("u3_fall_q", q3, 8'h3C);
    check("u3_fall_filled", {7'd0, f3}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
